scratch_pad_bank: RTL and testbench

//  Parametrised scratch-pad register bank on the OPB register bus; successor to the fixed two-register pad.
//  NUM_REGS addressable registers of DATA_W bits, with byte-enable writes, 1-cycle registered reads and read-valid.

---
 rtl/scratch_pad_bank.sv | 112 +++++++++++
 tb/tb_scratch_pad_bank.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/scratch_pad_bank.sv
// Parametrised OPB scratch-pad register bank: byte-enable writes, registered reads, lock and error pulse.
// Optional accepted-write counter is built when SCRATCH_PAD_WR_CNT_EN is defined.
module scratch_pad_bank #(
   parameter int unsigned NUM_REGS = 4,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ADDR_W   = 8,
   parameter logic [31:0] RST_EVEN = 32'h55AA_55AA,
   parameter logic [31:0] RST_ODD  = 32'hAA55_AA55
) (
   input  logic                  OPB_CLK,
   input  logic                  OPB_RST,
   input  logic [ADDR_W-1:0]     SP_ADDR,
   input  logic [DATA_W-1:0]     SP_DI,
   input  logic [DATA_W/8-1:0]   SP_BE,
   input  logic                  SP_WE,
   input  logic                  SP_RE,
   input  logic                  SP_LOCK,
   output logic [DATA_W-1:0]     SP_DO,
   output logic                  SP_DO_VLD,
   output logic                  SP_ERR,
   output logic [15:0]           SP_WR_CNT
);

   localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [DATA_W-1:0] EVEN_VAL = DATA_W'(RST_EVEN);
   localparam logic [DATA_W-1:0] ODD_VAL  = DATA_W'(RST_ODD);

   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic [DATA_W-1:0] do_q, do_d;
   logic              vld_q, vld_d;
   logic              err_q, err_d;

   logic              addr_ok;
   logic [IDX_W-1:0]  idx;
   logic              wr_acc;
   logic [DATA_W-1:0] be_mask;

   assign addr_ok = ({1'b0, SP_ADDR} < (ADDR_W+1)'(NUM_REGS));
   assign idx     = IDX_W'(SP_ADDR);
   assign wr_acc  = SP_WE && addr_ok && !SP_LOCK;

   always_comb begin
      be_mask = '0;
      for (int unsigned k = 0; k < DATA_W/8; k++) begin
         be_mask[k*8 +: 8] = {8{SP_BE[k]}};
      end
   end

   // Read data is taken from the current (pre-write) contents, giving read-before-write on a collision.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (wr_acc) begin
         regs_d[idx] = (regs_q[idx] & ~be_mask) | (SP_DI & be_mask);
      end
      do_d  = do_q;
      vld_d = 1'b0;
      if (SP_RE) begin
         do_d  = addr_ok ? regs_q[idx] : '0;
         vld_d = 1'b1;
      end
      err_d = (SP_WE && (!addr_ok || SP_LOCK)) || (SP_RE && !addr_ok);
   end

   always_ff @(posedge OPB_CLK) begin
      if (OPB_RST) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= (i % 2 == 0) ? EVEN_VAL : ODD_VAL;
         end
         do_q  <= '0;
         vld_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
         do_q  <= do_d;
         vld_q <= vld_d;
         err_q <= err_d;
      end
   end

   assign SP_DO     = do_q;
   assign SP_DO_VLD = vld_q;
   assign SP_ERR    = err_q;

`ifdef SCRATCH_PAD_WR_CNT_EN
   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (wr_acc && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge OPB_CLK) begin
      if (OPB_RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign SP_WR_CNT = cnt_q;
`else
   assign SP_WR_CNT = '0;
`endif

endmodule

// File: tb/tb_scratch_pad_bank.sv
// Directed, table-driven bench for scratch_pad_bank (default parameters).
module tb_scratch_pad_bank;

   logic        clk;
   logic        rst;
   logic [7:0]  addr;
   logic [31:0] di;
   logic [3:0]  be;
   logic        we, re, lock;
   logic [31:0] dout;
   logic        vld, err;
   logic [15:0] wr_cnt;

   int unsigned n_checks;
   int unsigned n_errors;

   scratch_pad_bank #(.NUM_REGS(4), .DATA_W(32), .ADDR_W(8)) dut (
      .OPB_CLK   (clk),
      .OPB_RST   (rst),
      .SP_ADDR   (addr),
      .SP_DI     (di),
      .SP_BE     (be),
      .SP_WE     (we),
      .SP_RE     (re),
      .SP_LOCK   (lock),
      .SP_DO     (dout),
      .SP_DO_VLD (vld),
      .SP_ERR    (err),
      .SP_WR_CNT (wr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic        re;
      logic        lock;
      logic [7:0]  addr;
      logic [31:0] di;
      logic [3:0]  be;
      logic        exp_vld;
      logic        exp_err;
      logic [31:0] exp_do;
   } vec_t;

   vec_t vecs [19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic w, input logic r, input logic l,
                        input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
      we = w; re = r; lock = l; addr = a; di = d; be = b;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      drive(1'b0, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
   endtask

   function automatic vec_t mk(input logic w, input logic r, input logic l, input logic [7:0] a,
                               input logic [31:0] d, input logic [3:0] b,
                               input logic ev, input logic ee, input logic [31:0] ed);
      vec_t v;
      v.we = w; v.re = r; v.lock = l; v.addr = a; v.di = d; v.be = b;
      v.exp_vld = ev; v.exp_err = ee; v.exp_do = ed;
      return v;
   endfunction

   initial begin
      logic [15:0] exp_cnt;
      n_checks = 0;
      n_errors = 0;

      //            we    re    lock  addr   di            be       vld   err   do
      vecs[0]  = mk(1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        4'h0,    1'b1, 1'b0, 32'h55AA55AA);
      vecs[1]  = mk(1'b0, 1'b1, 1'b0, 8'd1, 32'h0,        4'h0,    1'b1, 1'b0, 32'hAA55AA55);
      vecs[2]  = mk(1'b0, 1'b1, 1'b0, 8'd2, 32'h0,        4'h0,    1'b1, 1'b0, 32'h55AA55AA);
      vecs[3]  = mk(1'b0, 1'b1, 1'b0, 8'd3, 32'h0,        4'h0,    1'b1, 1'b0, 32'hAA55AA55);
      vecs[4]  = mk(1'b0, 1'b0, 1'b0, 8'd0, 32'h0,        4'h0,    1'b0, 1'b0, 32'hAA55AA55);
      vecs[5]  = mk(1'b1, 1'b0, 1'b0, 8'd1, 32'h12345678, 4'b0101, 1'b0, 1'b0, 32'hAA55AA55);
      vecs[6]  = mk(1'b0, 1'b1, 1'b0, 8'd1, 32'h0,        4'h0,    1'b1, 1'b0, 32'hAA34AA78);
      vecs[7]  = mk(1'b1, 1'b1, 1'b0, 8'd0, 32'hDEADBEEF, 4'hF,    1'b1, 1'b0, 32'h55AA55AA);
      vecs[8]  = mk(1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        4'h0,    1'b1, 1'b0, 32'hDEADBEEF);
      vecs[9]  = mk(1'b1, 1'b0, 1'b1, 8'd2, 32'h0,        4'hF,    1'b0, 1'b1, 32'hDEADBEEF);
      vecs[10] = mk(1'b0, 1'b1, 1'b1, 8'd2, 32'h0,        4'h0,    1'b1, 1'b0, 32'h55AA55AA);
      vecs[11] = mk(1'b0, 1'b1, 1'b0, 8'd9, 32'h0,        4'h0,    1'b1, 1'b1, 32'h00000000);
      vecs[12] = mk(1'b1, 1'b0, 1'b0, 8'd4, 32'hFFFFFFFF, 4'hF,    1'b0, 1'b1, 32'h00000000);
      vecs[13] = mk(1'b1, 1'b0, 1'b0, 8'd3, 32'h0,        4'h0,    1'b0, 1'b0, 32'h00000000);
      vecs[14] = mk(1'b0, 1'b1, 1'b0, 8'd3, 32'h0,        4'h0,    1'b1, 1'b0, 32'hAA55AA55);
      vecs[15] = mk(1'b1, 1'b0, 1'b0, 8'd3, 32'h11223344, 4'b1000, 1'b0, 1'b0, 32'hAA55AA55);
      vecs[16] = mk(1'b0, 1'b1, 1'b0, 8'd3, 32'h0,        4'h0,    1'b1, 1'b0, 32'h1155AA55);
      vecs[17] = mk(1'b1, 1'b1, 1'b0, 8'd9, 32'h1,        4'hF,    1'b1, 1'b1, 32'h00000000);
      vecs[18] = mk(1'b0, 1'b0, 1'b0, 8'd0, 32'h0,        4'h0,    1'b0, 1'b0, 32'h00000000);

      idle();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("reset_do", dout, 32'h0);
      chk("reset_vld", {31'd0, vld}, 32'd0);
      chk("reset_err", {31'd0, err}, 32'd0);
      chk("reset_cnt", {16'd0, wr_cnt}, 32'd0);

      for (int i = 0; i < 19; i++) begin
         drive(vecs[i].we, vecs[i].re, vecs[i].lock, vecs[i].addr, vecs[i].di, vecs[i].be);
         step();
         chk($sformatf("vec%0d_do", i), dout, vecs[i].exp_do);
         chk($sformatf("vec%0d_vld", i), {31'd0, vld}, {31'd0, vecs[i].exp_vld});
         chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      end

      // Accepted writes in the table: vectors 5, 7, 13, 15.
`ifdef SCRATCH_PAD_WR_CNT_EN
      exp_cnt = 16'd4;
`else
      exp_cnt = 16'd0;
`endif
      chk("wr_cnt_after_table", {16'd0, wr_cnt}, {16'd0, exp_cnt});

      // Reset restores register contents and clears the counter.
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst2_cnt", {16'd0, wr_cnt}, 32'd0);
      drive(1'b0, 1'b1, 1'b0, 8'd0, 32'h0, 4'h0);
      step();
      chk("rst2_reg0", dout, 32'h55AA55AA);
      drive(1'b0, 1'b1, 1'b0, 8'd3, 32'h0, 4'h0);
      step();
      chk("rst2_reg3", dout, 32'hAA55AA55);

      // Read then reset in the following cycle: outputs cleared.
      drive(1'b0, 1'b1, 1'b0, 8'd1, 32'h0, 4'h0);
      step();
      chk("pre_rst_vld", {31'd0, vld}, 32'd1);
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("post_rst_vld", {31'd0, vld}, 32'd0);
      chk("post_rst_do", dout, 32'h0);

      // Read (and bad write) sampled together with reset: discarded entirely.
      drive(1'b1, 1'b1, 1'b1, 8'd9, 32'h0, 4'hF);
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle();
      chk("mid_rst_vld", {31'd0, vld}, 32'd0);
      chk("mid_rst_err", {31'd0, err}, 32'd0);
      chk("mid_rst_do", dout, 32'h0);
      step();
      chk("mid_rst_vld_after", {31'd0, vld}, 32'd0);
      chk("mid_rst_err_after", {31'd0, err}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
